fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter sequencer and port arbiter for the instruction memory; the memory is byte-addressed, little-endian, with a combinational word read.
- Generates fetch addresses and registers the returned instruction word for decode.
- Applies branch redirects from execute and detects the terminal self-loop (`exit: beq x,x,exit`) as halt.
- Shares the single memory port between the core fetch path and a program loader, so the image can be rewritten between runs without relying on reset-time init.

Parameters:
- ADDR_W, 32, fetch/branch address width.
- MEM_BYTES, 56, instruction memory size in bytes; must be a multiple of 4.
- RESET_PC, 0, first fetch address after start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state when 0.
- start  in  1  one-cycle pulse; begins execution from RESET_PC.
- stall  in  1  holds pc and instr (decode back-pressure).
- br_taken  in  1  execute-stage redirect valid.
- br_pc  in  ADDR_W  address of the redirecting branch.
- br_target  in  ADDR_W  redirect destination.
- load_req  in  1  loader requests the memory port.
- load_addr  in  ADDR_W  loader word address.
- load_data  in  32  loader word.
- load_gnt  out  1  loader write accepted this cycle.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_we  out  1  word write strobe to memory.
- mem_wdata  out  32  write word.
- inst_code  in  32  combinational read data from memory.
- pc  out  ADDR_W  current fetch address.
- instr  out  32  registered instruction.
- instr_valid  out  1  instr is valid for decode.
- halted  out  1  program reached the self-loop.
- fault  out  1  illegal fetch target.

Behaviour:
- States: IDLE, RUN, HALT, FAULT; 2-bit encoding; reset state is IDLE.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, halted=0, fault=0, load_gnt=0, mem_we=0.
- IDLE:
  - load_req=1 → load_gnt=1 and mem_we=1 in the same cycle; mem_addr=load_addr, mem_wdata=load_data. One word per cycle.
  - start=1 with load_req=0 → RUN, pc=RESET_PC.
  - start and load_req together → the load wins and start is dropped.
- RUN:
  - mem_addr=pc combinationally.
  - Each non-stalled cycle: instr<=inst_code, instr_valid<=1, pc<=pc+4. Latency is 1 cycle from pc to instr.
  - stall=1 → pc, instr and instr_valid hold.
  - br_taken=1 → pc<=br_target and instr_valid<=0 for one cycle (squash). br_taken has priority over stall.
  - br_taken=1 with br_target==br_pc → HALT; pc holds br_target, instr_valid<=0.
  - A target that is misaligned (bits[1:0]≠0) or ≥MEM_BYTES, from either a redirect or sequential pc+4 → FAULT; instr_valid<=0, mem_addr frozen.
  - load_req is ignored in RUN: load_gnt=0 and no write.
- HALT: halted=1. Loads are accepted exactly as in IDLE. start → RUN from RESET_PC and clears halted.
- FAULT: fault=1 and sticky. Only reset exits FAULT; start and load_req are ignored.
- Loader writes to an address that is misaligned or ≥MEM_BYTES are still granted but mem_we=0, so the write is dropped silently.
- Reset asserted mid-run: the next fetch after deassert waits for start. Memory contents are untouched by this block.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs: fetch_count (32-bit) and squash_count (16-bit), plus input perf_clr.
  - fetch_count increments on every cycle with instr_valid<=1.
  - squash_count increments on every br_taken in RUN.
  - Both clear on reset, on perf_clr, and on start.
  - Both saturate at all-ones rather than wrapping.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `fetch_pkg`:
  - State enum: FS_IDLE, FS_RUN, FS_HALT, FS_FAULT.
  - Constants INSTR_BYTES=4 and NOP_WORD=32'h00000013.
  - Function pc_legal(addr, MEM_BYTES).
- One sub-module, `fetch_port_mux`: combinational arbitration of mem_addr, mem_we and mem_wdata between loader and fetch.
- The state machine and PC register stay in the top module.

Test Plan:
- Load the words 0x00A00413 @0 and 0x00148493 @4, then start → instr=0x00A00413 one cycle after start, then 0x00148493, with pc=0,4,8.
- stall held for 3 cycles at pc=8 → pc, instr and instr_valid unchanged; fetch resumes at 12 after stall drops.
- br_taken with br_pc=32, br_target=12 → exactly one squash cycle (instr_valid=0), then instr=mem[12].
- br_taken with br_pc=36, br_target=36 → halted=1 the next cycle. A load_req issued afterward is granted, and start restarts at pc=0.
- br_target=6 or br_target=60 → fault=1 and sticky; start is ignored; clears only on reset.
- load_req=1 during RUN → load_gnt=0 and mem_we=0 throughout. Asynchronous reset asserted mid-cycle → pc=0 and instr_valid=0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, constants and address-legality helper for the instruction fetch sequencer.
// Used by fetch_sequencer and fetch_port_mux.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_HALT  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

  // Word-aligned and inside the instruction memory.
  function automatic logic pc_legal(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr < mem_bytes);
  endfunction

endpackage

// File: rtl/fetch_port_mux.sv
// Memory port arbiter: loader owns the port in IDLE/HALT when requesting, fetch otherwise.
// Latency: combinational. Backpressure: loader is refused (load_gnt=0) outside IDLE/HALT.
// Out-of-range loader writes are granted but the write strobe is suppressed.
module fetch_port_mux
  import fetch_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 56
) (
  input  fetch_state_t      state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  always_comb begin
    load_gnt  = load_req && ((state == FS_IDLE) || (state == FS_HALT));
    mem_addr  = pc;
    mem_we    = 1'b0;
    mem_wdata = NOP_WORD;
    if (load_gnt) begin
      mem_addr  = load_addr;
      mem_wdata = load_data;
      mem_we    = pc_legal(32'(load_addr), MEM_BYTES);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer + fetch/loader port arbitration; optional perf counters under FETCH_PERF_EN.
// Latency: 1 cycle pc -> instr. Backpressure: stall holds pc/instr; loader refused while running.
// Branch redirect beats stall; a self-targeting branch halts, an illegal target faults (sticky).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int unsigned        MEM_BYTES = 56,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       inst_code,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       fetch_count,
  output logic [15:0]       squash_count
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_seq;
  logic              seq_legal;
  logic              tgt_legal;
  logic              start_go;

  assign pc_seq    = pc + ADDR_W'(INSTR_BYTES);
  assign seq_legal = pc_legal(32'(pc_seq), MEM_BYTES);
  assign tgt_legal = pc_legal(32'(br_target), MEM_BYTES);
  // A simultaneous load request wins the port, so start is dropped.
  assign start_go  = start && !load_req;

  fetch_port_mux #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_port_mux (
    .state     (state),
    .pc        (pc),
    .load_req  (load_req),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_gnt  (load_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FS_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        FS_IDLE, FS_HALT: begin
          if (start_go) begin
            state  <= FS_RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
          end
        end
        FS_RUN: begin
          if (br_taken) begin
            instr_valid <= 1'b0;
            if (!tgt_legal) begin
              state <= FS_FAULT;
              fault <= 1'b1;
            end else begin
              pc <= br_target;
              if (br_target == br_pc) begin
                state  <= FS_HALT;
                halted <= 1'b1;
              end
            end
          end else if (!stall) begin
            if (!seq_legal) begin
              // pc stays put so the memory address is frozen on the last legal fetch.
              state       <= FS_FAULT;
              fault       <= 1'b1;
              instr_valid <= 1'b0;
            end else begin
              instr       <= inst_code;
              instr_valid <= 1'b1;
              pc          <= pc_seq;
            end
          end
        end
        default: begin
          fault <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic squash_inc;
  logic perf_zero;

  assign fetch_inc  = (state == FS_RUN) && !br_taken && !stall && seq_legal;
  assign squash_inc = (state == FS_RUN) && br_taken;
  assign perf_zero  = perf_clr || (start_go && ((state == FS_IDLE) || (state == FS_HALT)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else if (perf_zero) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != '1))
        fetch_count <= fetch_count + 32'd1;
      if (squash_inc && (squash_count != '1))
        squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: word-array memory model, golden image, fetch scoreboard.
module tb_fetch_sequencer;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 56;
  localparam int WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_target = '0;
  logic        load_req = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] inst_code;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] fetch_count;
  logic [15:0] squash_count;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES),
    .RESET_PC  (32'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_target   (br_target),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_gnt    (load_gnt),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .inst_code   (inst_code),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fault       (fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_clr     (perf_clr),
    .fetch_count  (fetch_count),
    .squash_count (squash_count)
`endif
  );

  // Instruction memory written only through the DUT port; img holds what the bench loaded.
  logic [31:0] mem [0:WORDS-1];
  logic [31:0] img [0:WORDS-1];

  always_comb begin
    inst_code = 32'h0;
    if (mem_addr < 32'(MEM_BYTES))
      inst_code = mem[int'(mem_addr >> 2)];
  end

  always @(posedge clk)
    if (mem_we && (mem_addr < 32'(MEM_BYTES)))
      mem[int'(mem_addr >> 2)] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One advancing fetch cycle: expectation queued before the edge, checked after it.
  task automatic run_step(input string tag);
    exp_t e;
    stall    = 1'b0;
    br_taken = 1'b0;
    #1;
    chk({tag, "_gnt"}, load_gnt, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    sb.push_back('{pc: exp_pc + 32'd4, instr: img[int'(exp_pc >> 2)]});
    tick();
    e = sb.pop_front();
    chk({tag, "_instr"}, instr, e.instr);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_vld"}, instr_valid, 1'b1);
    exp_pc = e.pc;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic exp_we);
    load_req  = 1'b1;
    load_addr = a;
    load_data = d;
    #1;
    chk("load_gnt", load_gnt, 1'b1);
    chk("load_we", mem_we, exp_we);
    tick();
    load_req = 1'b0;
    if (exp_we)
      img[int'(a >> 2)] = d;
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    start  = 1'b0;
    exp_pc = 32'd0;
  endtask

  task automatic branch(input logic [31:0] bpc, input logic [31:0] tgt);
    br_taken  = 1'b1;
    br_pc     = bpc;
    br_target = tgt;
    tick();
    br_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_vld", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_gnt", load_gnt, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < WORDS; i++)
      load_word(32'(i * 4), (i == 0) ? 32'h00A00413 : (i == 1) ? 32'h00148493 : 32'h1000_0000 + 32'(i), 1'b1);
    load_word(32'd6, 32'hBAD0_0006, 1'b0);
    load_word(32'd60, 32'hBAD0_003C, 1'b0);

    // start together with a load: the load wins and the core stays idle
    start = 1'b1;
    load_req = 1'b1;
    load_addr = 32'd8;
    load_data = img[2];
    #1;
    chk("start_load_gnt", load_gnt, 1'b1);
    tick();
    start = 1'b0;
    load_req = 1'b0;
    tick();
    chk("start_drop_vld", instr_valid, 1'b0);
    load_word(32'd8, img[2], 1'b1);

    start = 1'b1;
    tick();
    start  = 1'b0;
    exp_pc = 32'd0;
    chk("start_pc", pc, 32'd0);
    chk("start_vld", instr_valid, 1'b0);

    // loader keeps requesting throughout RUN; it must never get the port
    load_req  = 1'b1;
    load_addr = 32'd0;
    load_data = 32'hDEAD_BEEF;
    run_step("f0");
    run_step("f1");

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_gnt", load_gnt, 1'b0);
      chk("stall_we", mem_we, 1'b0);
      tick();
      chk("stall_pc", pc, 32'd8);
      chk("stall_instr", instr, img[1]);
      chk("stall_vld", instr_valid, 1'b1);
    end
    run_step("f2");

    // redirect while stalled: redirect has priority
    stall = 1'b1;
    branch(32'd32, 32'd12);
    stall = 1'b0;
    chk("br_pc", pc, 32'd12);
    chk("br_squash", instr_valid, 1'b0);
    exp_pc = 32'd12;
    run_step("br_fetch");
    load_req = 1'b0;

    branch(32'd36, 32'd36);
    chk("halt_halted", halted, 1'b1);
    chk("halt_pc", pc, 32'd36);
    chk("halt_vld", instr_valid, 1'b0);
    tick();
    chk("halt_sticky", halted, 1'b1);
    load_word(32'd40, 32'hCAFE_0040, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_halted", halted, 1'b0);
    chk("restart_pc", pc, 32'd0);
    exp_pc = 32'd0;
    run_step("rs0");

    // sequential run off the end of memory
    branch(32'd4, 32'd48);
    exp_pc = 32'd48;
    run_step("f48");
    tick();
    chk("seqf_fault", fault, 1'b1);
    chk("seqf_vld", instr_valid, 1'b0);
    chk("seqf_pc", pc, 32'd52);
    chk("seqf_maddr", mem_addr, 32'd52);
    start = 1'b1;
    load_req = 1'b1;
    load_addr = 32'd0;
    #1;
    chk("fault_gnt", load_gnt, 1'b0);
    chk("fault_we", mem_we, 1'b0);
    tick();
    start = 1'b0;
    load_req = 1'b0;
    tick();
    chk("fault_sticky", fault, 1'b1);
    chk("fault_pc", pc, 32'd52);

    restart();
    chk("rst_clr_fault", fault, 1'b0);
    branch(32'd0, 32'd6);
    chk("mis_fault", fault, 1'b1);
    chk("mis_vld", instr_valid, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mis_sticky", fault, 1'b1);

    restart();
    branch(32'd0, 32'd60);
    chk("oor_fault", fault, 1'b1);

    restart();
    run_step("m0");
    run_step("m1");
    #3;
    reset = 1'b0;
    #1;
    chk("async_pc", pc, 32'd0);
    chk("async_vld", instr_valid, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_pc", pc, 32'd0);
    chk("post_rst_vld", instr_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
